sq_mt: RTL and testbench

- Parametrised multi-thread store queue. Successor to the fixed 2-thread SQ.
- Holds dispatched stores per thread in circular buffers and resolves address and data out of order.
- Marks stores committed in ROB order, squashes uncommitted stores on mispredict, and drains committed stores to the D-cache via a valid/ready request port with round-robin thread arbitration.
- Sits between dispatch/rename, the AGU/CDB writeback, the ROB commit stage and the memory interface.

---
 rtl/sq_mt_if.sv | 65 ++++++
 rtl/sq_mt.sv | 242 ++++++++++++++++++++++++
 tb/tb_sq_mt.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sq_mt_if.sv
// Port bundle of the multi-thread store queue: dispatch, address/data resolve,
// commit, squash, D-cache store request and per-thread status.
interface sq_mt_if #(
  parameter int SQ_DEPTH    = 8,
  parameter int NUM_THREADS = 2,
  parameter int ROB_IDX_W   = 5,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64
);
  localparam int IDX_W = $clog2(SQ_DEPTH);
  localparam int TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  logic [1:0]                       disp_valid;
  logic [2*TID_W-1:0]               disp_tid;
  logic [2*ROB_IDX_W-1:0]           disp_rob_idx;
  logic [2*DATA_W-1:0]              disp_data;
  logic [1:0]                       disp_data_valid;
  logic [2*IDX_W-1:0]               disp_sq_idx;

  logic                             agu_valid;
  logic [TID_W-1:0]                 agu_tid;
  logic [IDX_W-1:0]                 agu_sq_idx;
  logic [ADDR_W-1:0]                agu_addr;

  logic                             dat_valid;
  logic [TID_W-1:0]                 dat_tid;
  logic [IDX_W-1:0]                 dat_sq_idx;
  logic [DATA_W-1:0]                dat_data;

  logic [NUM_THREADS-1:0]           cmt_valid;
  logic [NUM_THREADS*ROB_IDX_W-1:0] cmt_rob_idx;
  logic [NUM_THREADS-1:0]           squash;

  logic                             mem_req_valid;
  logic [ADDR_W-1:0]                mem_req_addr;
  logic [DATA_W-1:0]                mem_req_data;
  logic [TID_W-1:0]                 mem_req_tid;
  logic                             mem_req_ready;

  logic [NUM_THREADS-1:0]           full;
  logic [NUM_THREADS-1:0]           empty;
  logic                             cmt_err;

  modport slave (
    input  disp_valid, disp_tid, disp_rob_idx, disp_data, disp_data_valid,
    output disp_sq_idx,
    input  agu_valid, agu_tid, agu_sq_idx, agu_addr,
    input  dat_valid, dat_tid, dat_sq_idx, dat_data,
    input  cmt_valid, cmt_rob_idx, squash,
    output mem_req_valid, mem_req_addr, mem_req_data, mem_req_tid,
    input  mem_req_ready,
    output full, empty, cmt_err
  );

  modport master (
    output disp_valid, disp_tid, disp_rob_idx, disp_data, disp_data_valid,
    input  disp_sq_idx,
    output agu_valid, agu_tid, agu_sq_idx, agu_addr,
    output dat_valid, dat_tid, dat_sq_idx, dat_data,
    output cmt_valid, cmt_rob_idx, squash,
    input  mem_req_valid, mem_req_addr, mem_req_data, mem_req_tid,
    output mem_req_ready,
    input  full, empty, cmt_err
  );
endinterface

// File: rtl/sq_mt.sv
// Multi-thread store queue: per-thread circular buffers with out-of-order
// address/data resolve, in-order commit, squash, and round-robin D-cache drain.
module sq_mt #(
  parameter int SQ_DEPTH    = 8,
  parameter int NUM_THREADS = 2,
  parameter int ROB_IDX_W   = 5,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64
) (
  input  logic   clock,
  input  logic   reset,
  sq_mt_if.slave bus
);
  localparam int IDX_W = $clog2(SQ_DEPTH);
  localparam int TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int CNT_W = IDX_W + 1;
  localparam int NT    = NUM_THREADS;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t                r_state, w_state_nxt;

  logic [IDX_W-1:0]      r_head  [NT];
  logic [IDX_W-1:0]      r_cptr  [NT];
  logic [IDX_W-1:0]      r_tail  [NT];
  logic [CNT_W-1:0]      r_count [NT];

  logic [SQ_DEPTH-1:0]   r_valid  [NT];
  logic [SQ_DEPTH-1:0]   r_addr_v [NT];
  logic [SQ_DEPTH-1:0]   r_data_v [NT];
  logic [SQ_DEPTH-1:0]   r_cmt    [NT];
  logic [ADDR_W-1:0]     r_addr [NT][SQ_DEPTH];
  logic [DATA_W-1:0]     r_data [NT][SQ_DEPTH];
  logic [ROB_IDX_W-1:0]  r_rob  [NT][SQ_DEPTH];

  logic [TID_W-1:0]      r_rr;
  logic [TID_W-1:0]      r_req_tid;
  logic [ADDR_W-1:0]     r_req_addr;
  logic [DATA_W-1:0]     r_req_data;
  logic                  r_cmt_err;

  logic [TID_W-1:0]      w_dtid  [2];
  logic [TID_W-1:0]      w_tsel  [2];
  logic [ROB_IDX_W-1:0]  w_drob  [2];
  logic [DATA_W-1:0]     w_ddata [2];
  logic [IDX_W-1:0]      w_didx  [2];
  logic [1:0]            w_dacc;
  logic                  w_same;

  logic [NT-1:0]         w_cok, w_cerr, w_elig, w_drain;
  logic [IDX_W-1:0]      w_cptr_nxt [NT];
  logic [IDX_W-1:0]      w_span     [NT];
  logic [CNT_W-1:0]      w_keep     [NT];
  logic [CNT_W-1:0]      w_alloc    [NT];

  logic                  w_gnt_v;
  logic [TID_W-1:0]      w_gnt_tid;
  int                    w_c;

  function automatic logic tid_ok(input logic [TID_W-1:0] t);
    return int'(t) < NT;
  endfunction

  // Dispatch: slot1 lands one past slot0 when both target the same thread
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      w_dtid[k]  = bus.disp_tid[k*TID_W +: TID_W];
      w_tsel[k]  = tid_ok(w_dtid[k]) ? w_dtid[k] : '0;
      w_drob[k]  = bus.disp_rob_idx[k*ROB_IDX_W +: ROB_IDX_W];
      w_ddata[k] = bus.disp_data[k*DATA_W +: DATA_W];
    end
    w_dacc[0] = bus.disp_valid[0] && tid_ok(w_dtid[0]) && !bus.squash[w_tsel[0]] &&
                (r_count[w_tsel[0]] <= CNT_W'(SQ_DEPTH - 1));
    w_same    = w_dacc[0] && (w_dtid[0] == w_dtid[1]);
    w_dacc[1] = bus.disp_valid[1] && tid_ok(w_dtid[1]) && !bus.squash[w_tsel[1]] &&
                (r_count[w_tsel[1]] <= CNT_W'(w_same ? SQ_DEPTH - 2 : SQ_DEPTH - 1));
    w_didx[0] = r_tail[w_tsel[0]];
    w_didx[1] = r_tail[w_tsel[1]] + IDX_W'(w_same);
    bus.disp_sq_idx = {w_didx[1], w_didx[0]};
  end

  always_comb begin
    for (int t = 0; t < NT; t++) begin
      w_cok[t]      = bus.cmt_valid[t] && r_valid[t][r_cptr[t]] && !r_cmt[t][r_cptr[t]] &&
                      (r_rob[t][r_cptr[t]] == bus.cmt_rob_idx[t*ROB_IDX_W +: ROB_IDX_W]);
      w_cerr[t]     = bus.cmt_valid[t] && !w_cok[t];
      w_cptr_nxt[t] = r_cptr[t] + IDX_W'(w_cok[t]);
      w_span[t]     = w_cptr_nxt[t] - r_head[t];
      w_keep[t]     = {1'b0, w_span[t]};
      // cptr wrapped all the way round to head: every entry is committed
      if (w_span[t] == '0 && r_valid[t][r_head[t]] && r_cmt[t][r_head[t]])
        w_keep[t] = CNT_W'(SQ_DEPTH);
      w_alloc[t]    = CNT_W'(w_dacc[0] && (int'(w_dtid[0]) == t)) +
                      CNT_W'(w_dacc[1] && (int'(w_dtid[1]) == t));
      w_elig[t]     = r_valid[t][r_head[t]] && r_cmt[t][r_head[t]] &&
                      r_addr_v[t][r_head[t]] && r_data_v[t][r_head[t]];
      w_drain[t]    = (r_state == S_SEND) && bus.mem_req_ready && (int'(r_req_tid) == t);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < NT; t++) begin
        r_head[t]  <= '0;
        r_cptr[t]  <= '0;
        r_tail[t]  <= '0;
        r_count[t] <= '0;
      end
    end else begin
      for (int t = 0; t < NT; t++) begin
        r_head[t] <= r_head[t] + IDX_W'(w_drain[t]);
        r_cptr[t] <= w_cptr_nxt[t];
        if (bus.squash[t]) begin
          r_tail[t]  <= w_cptr_nxt[t];
          r_count[t] <= w_keep[t] - CNT_W'(w_drain[t]);
        end else begin
          r_tail[t]  <= r_tail[t] + w_alloc[t][IDX_W-1:0];
          r_count[t] <= r_count[t] + w_alloc[t] - CNT_W'(w_drain[t]);
        end
      end
    end
  end

  // Later assignments win: dispatch overrides resolve, squash and drain
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < NT; t++) begin
        r_valid[t]  <= '0;
        r_addr_v[t] <= '0;
        r_data_v[t] <= '0;
        r_cmt[t]    <= '0;
      end
    end else begin
      for (int t = 0; t < NT; t++) begin
        for (int i = 0; i < SQ_DEPTH; i++) begin
          if (bus.agu_valid && int'(bus.agu_tid) == t && int'(bus.agu_sq_idx) == i && r_valid[t][i])
            r_addr_v[t][i] <= 1'b1;
          if (bus.dat_valid && int'(bus.dat_tid) == t && int'(bus.dat_sq_idx) == i && r_valid[t][i])
            r_data_v[t][i] <= 1'b1;
          if (w_cok[t] && int'(r_cptr[t]) == i)
            r_cmt[t][i] <= 1'b1;
          if (bus.squash[t] && r_valid[t][i] && !r_cmt[t][i] && !(w_cok[t] && int'(r_cptr[t]) == i))
            r_valid[t][i] <= 1'b0;
          if (w_drain[t] && int'(r_head[t]) == i) begin
            r_valid[t][i] <= 1'b0;
            r_cmt[t][i]   <= 1'b0;
          end
          for (int k = 0; k < 2; k++) begin
            if (w_dacc[k] && int'(w_dtid[k]) == t && int'(w_didx[k]) == i) begin
              r_valid[t][i]  <= 1'b1;
              r_addr_v[t][i] <= 1'b0;
              r_data_v[t][i] <= bus.disp_data_valid[k];
              r_cmt[t][i]    <= 1'b0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int t = 0; t < NT; t++) begin
      for (int i = 0; i < SQ_DEPTH; i++) begin
        if (bus.agu_valid && int'(bus.agu_tid) == t && int'(bus.agu_sq_idx) == i && r_valid[t][i])
          r_addr[t][i] <= bus.agu_addr;
        if (bus.dat_valid && int'(bus.dat_tid) == t && int'(bus.dat_sq_idx) == i && r_valid[t][i])
          r_data[t][i] <= bus.dat_data;
        for (int k = 0; k < 2; k++) begin
          if (w_dacc[k] && int'(w_dtid[k]) == t && int'(w_didx[k]) == i) begin
            r_data[t][i] <= w_ddata[k];
            r_rob[t][i]  <= w_drob[k];
          end
        end
      end
    end
  end

  // Round-robin: scanning downward leaves the thread closest to r_rr as winner
  always_comb begin
    w_gnt_v   = 1'b0;
    w_gnt_tid = '0;
    w_c       = 0;
    for (int k = NT - 1; k >= 0; k--) begin
      w_c = int'(r_rr) + k;
      if (w_c >= NT) w_c = w_c - NT;
      if (w_elig[w_c]) begin
        w_gnt_v   = 1'b1;
        w_gnt_tid = TID_W'(w_c);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt_v) w_state_nxt = S_SEND;
      S_SEND:  if (bus.mem_req_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req_valid = (r_state == S_SEND);
    bus.mem_req_addr  = r_req_addr;
    bus.mem_req_data  = r_req_data;
    bus.mem_req_tid   = r_req_tid;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr       <= '0;
      r_req_tid  <= '0;
      r_req_addr <= '0;
      r_req_data <= '0;
      r_cmt_err  <= 1'b0;
    end else begin
      r_cmt_err <= |w_cerr;
      if (r_state == S_IDLE && w_gnt_v) begin
        r_req_tid  <= w_gnt_tid;
        r_req_addr <= r_addr[w_gnt_tid][r_head[w_gnt_tid]];
        r_req_data <= r_data[w_gnt_tid][r_head[w_gnt_tid]];
      end
      if (r_state == S_SEND && bus.mem_req_ready)
        r_rr <= (int'(r_req_tid) == NT - 1) ? '0 : r_req_tid + 1'b1;
    end
  end

  always_comb begin
    bus.full    = '0;
    bus.empty   = '0;
    for (int t = 0; t < NT; t++) begin
      bus.full[t]  = r_count[t] > CNT_W'(SQ_DEPTH - 2);
      bus.empty[t] = r_count[t] == '0;
    end
    bus.cmt_err = r_cmt_err;
  end
endmodule

// File: tb/tb_sq_mt.sv
// Directed bench for sq_mt: reset, drain ordering and hold, full/wrap,
// squash, round-robin alternation and commit-error pulse.
module tb_sq_mt;
  localparam int D = 8, NT = 2, RW = 5, AW = 64, DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sq_mt_if #(.SQ_DEPTH(D), .NUM_THREADS(NT), .ROB_IDX_W(RW), .ADDR_W(AW), .DATA_W(DW)) b ();
  sq_mt #(.SQ_DEPTH(D), .NUM_THREADS(NT), .ROB_IDX_W(RW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clk), .reset(rst), .bus(b.slave));

  int n_run  = 0;
  int n_fail = 0;

  task automatic step(); @(posedge clk); #1; endtask

  task automatic clr_in();
    b.disp_valid = '0; b.disp_tid = '0; b.disp_rob_idx = '0; b.disp_data = '0; b.disp_data_valid = '0;
    b.agu_valid = 1'b0; b.agu_tid = '0; b.agu_sq_idx = '0; b.agu_addr = '0;
    b.dat_valid = 1'b0; b.dat_tid = '0; b.dat_sq_idx = '0; b.dat_data = '0;
    b.cmt_valid = '0; b.cmt_rob_idx = '0; b.squash = '0; b.mem_req_ready = 1'b0;
  endtask

  task automatic do_reset();
    clr_in(); rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  task automatic disp(input int tid, input int rob, input logic [63:0] d);
    b.disp_valid = 2'b01; b.disp_tid = 2'(tid); b.disp_rob_idx = 10'(rob);
    b.disp_data = 128'(d); b.disp_data_valid = 2'b01;
    step(); b.disp_valid = '0;
  endtask

  task automatic agu(input int tid, input int idx, input logic [63:0] a);
    b.agu_valid = 1'b1; b.agu_tid = 1'(tid); b.agu_sq_idx = 3'(idx); b.agu_addr = a;
    step(); b.agu_valid = 1'b0;
  endtask

  task automatic commit(input int tid, input int rob);
    b.cmt_valid = 2'(1 << tid); b.cmt_rob_idx = 10'(rob << (tid * RW));
    step(); b.cmt_valid = '0;
  endtask

  task automatic tail_of(input int tid, output int idx);
    b.disp_tid = 2'(tid); #1; idx = int'(b.disp_sq_idx[2:0]);
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (b.mem_req_valid !== 1'b1 && n < 20) begin step(); n++; end
    ok = (b.mem_req_valid === 1'b1);
  endtask

  task automatic test_reset();
    clr_in(); rst = 1'b1; step(); step();
    n_run++; if (b.mem_req_valid !== 1'b0 || b.mem_req_addr !== '0 || b.mem_req_data !== '0 || b.mem_req_tid !== '0) begin
      n_fail++; $display("FAIL reset_req: got v=%b a=%h d=%h t=%h want all 0", b.mem_req_valid, b.mem_req_addr, b.mem_req_data, b.mem_req_tid); end
    n_run++; if (b.empty !== 2'b11 || b.full !== 2'b00 || b.cmt_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_status: got empty=%b full=%b err=%b want 11 00 0", b.empty, b.full, b.cmt_err); end
    rst = 1'b0;
  endtask

  task automatic test_drain_hold();
    bit ok; int t;
    do_reset();
    disp(0, 3, 64'hD3); disp(0, 4, 64'hD4);
    tail_of(0, t);
    n_run++; if (t != 2) begin n_fail++; $display("FAIL drain_tail: got %0d want 2", t); end
    agu(0, 0, 64'h100); agu(0, 1, 64'h108);
    commit(0, 3); commit(0, 4);
    wait_req(ok);
    n_run++; if (!ok || b.mem_req_addr !== 64'h100 || b.mem_req_data !== 64'hD3 || b.mem_req_tid !== 1'b0) begin
      n_fail++; $display("FAIL drain_req0: got v=%b a=%h d=%h want 1 100 d3", b.mem_req_valid, b.mem_req_addr, b.mem_req_data); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_run++; if (b.mem_req_valid !== 1'b1 || b.mem_req_addr !== 64'h100 || b.mem_req_data !== 64'hD3) begin
        n_fail++; $display("FAIL drain_hold%0d: got v=%b a=%h want 1 100", i, b.mem_req_valid, b.mem_req_addr); end
    end
    b.mem_req_ready = 1'b1; step(); b.mem_req_ready = 1'b0;
    n_run++; if (b.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL drain_gap: got v=%b want 0", b.mem_req_valid); end
    wait_req(ok);
    n_run++; if (!ok || b.mem_req_addr !== 64'h108 || b.mem_req_data !== 64'hD4) begin
      n_fail++; $display("FAIL drain_req1: got v=%b a=%h d=%h want 1 108 d4", b.mem_req_valid, b.mem_req_addr, b.mem_req_data); end
    b.mem_req_ready = 1'b1; step(); b.mem_req_ready = 1'b0;
    n_run++; if (b.empty !== 2'b11) begin n_fail++; $display("FAIL drain_empty: got %b want 11", b.empty); end
  endtask

  task automatic test_full_wrap();
    bit ok; int t;
    do_reset();
    for (int i = 0; i < 7; i++) disp(1, i, 64'(i));
    n_run++; if (b.full !== 2'b10 || b.empty !== 2'b01) begin
      n_fail++; $display("FAIL full_set: got full=%b empty=%b want 10 01", b.full, b.empty); end
    agu(1, 0, 64'h200); commit(1, 0);
    b.mem_req_ready = 1'b1;
    wait_req(ok);
    n_run++; if (!ok || b.mem_req_addr !== 64'h200 || b.mem_req_tid !== 1'b1) begin
      n_fail++; $display("FAIL full_drain: got v=%b a=%h t=%h want 1 200 1", b.mem_req_valid, b.mem_req_addr, b.mem_req_tid); end
    step(); b.mem_req_ready = 1'b0;
    n_run++; if (b.full !== 2'b00) begin n_fail++; $display("FAIL full_clear: got %b want 00", b.full); end
    tail_of(1, t);
    n_run++; if (t != 7) begin n_fail++; $display("FAIL wrap_tail7: got %0d want 7", t); end
    disp(1, 7, 64'h7);
    tail_of(1, t);
    n_run++; if (t != 0) begin n_fail++; $display("FAIL wrap_tail0: got %0d want 0", t); end
    disp(1, 8, 64'h8);
    tail_of(1, t);
    n_run++; if (t != 1 || b.full !== 2'b10) begin n_fail++; $display("FAIL wrap_full: got tail=%0d full=%b want 1 10", t, b.full); end
    disp(1, 9, 64'h9);
    tail_of(1, t);
    n_run++; if (t != 1) begin n_fail++; $display("FAIL overflow_drop: got tail=%0d want 1", t); end
  endtask

  task automatic test_squash();
    bit ok; int t;
    do_reset();
    for (int i = 0; i < 5; i++) disp(0, i, 64'h50 + 64'(i));
    agu(0, 0, 64'h300); agu(0, 1, 64'h308);
    commit(0, 0); commit(0, 1);
    b.squash = 2'b01; b.disp_valid = 2'b01; b.disp_tid = 2'b00; b.disp_rob_idx = 10'd9; b.disp_data_valid = 2'b01;
    step();
    b.squash = '0; b.disp_valid = '0;
    tail_of(0, t);
    n_run++; if (t != 2 || b.empty[0] !== 1'b0) begin
      n_fail++; $display("FAIL squash_tail: got tail=%0d empty0=%b want 2 0", t, b.empty[0]); end
    commit(0, 2);
    n_run++; if (b.cmt_err !== 1'b1) begin n_fail++; $display("FAIL squash_invalid: got err=%b want 1", b.cmt_err); end
    b.mem_req_ready = 1'b1;
    wait_req(ok);
    n_run++; if (!ok || b.mem_req_addr !== 64'h300 || b.mem_req_data !== 64'h50) begin
      n_fail++; $display("FAIL squash_req0: got v=%b a=%h d=%h want 1 300 50", b.mem_req_valid, b.mem_req_addr, b.mem_req_data); end
    step();
    wait_req(ok);
    n_run++; if (!ok || b.mem_req_addr !== 64'h308 || b.mem_req_data !== 64'h51) begin
      n_fail++; $display("FAIL squash_req1: got v=%b a=%h d=%h want 1 308 51", b.mem_req_valid, b.mem_req_addr, b.mem_req_data); end
    step(); b.mem_req_ready = 1'b0;
    n_run++; if (b.empty !== 2'b11) begin n_fail++; $display("FAIL squash_count: got empty=%b want 11", b.empty); end
  endtask

  task automatic test_back_to_back();
    int gtid [6]; logic [63:0] gaddr [6]; logic [63:0] gdata [6];
    int got = 0; int n = 0; logic [63:0] ea, ed;
    do_reset();
    b.disp_valid = 2'b11; b.disp_data_valid = 2'b11;
    b.disp_tid = 2'b00; b.disp_rob_idx = {5'd11, 5'd10}; b.disp_data = {64'hA1, 64'hA0}; #1;
    n_run++; if (b.disp_sq_idx !== 6'b001_000) begin n_fail++; $display("FAIL dual_same_t0: got %b want 001000", b.disp_sq_idx); end
    step();
    b.disp_tid = 2'b11; b.disp_rob_idx = {5'd21, 5'd20}; b.disp_data = {64'hB1, 64'hB0}; #1;
    n_run++; if (b.disp_sq_idx !== 6'b001_000) begin n_fail++; $display("FAIL dual_same_t1: got %b want 001000", b.disp_sq_idx); end
    step();
    b.disp_tid = 2'b10; b.disp_rob_idx = {5'd22, 5'd12}; b.disp_data = {64'hB2, 64'hA2}; #1;
    n_run++; if (b.disp_sq_idx !== 6'b010_010) begin n_fail++; $display("FAIL dual_split: got %b want 010010", b.disp_sq_idx); end
    step();
    b.disp_valid = '0;
    for (int i = 0; i < 3; i++) begin agu(0, i, 64'h400 + 64'(8*i)); agu(1, i, 64'h500 + 64'(8*i)); end
    for (int i = 0; i < 3; i++) begin
      b.cmt_valid = 2'b11; b.cmt_rob_idx = {5'(20 + i), 5'(10 + i)}; step();
    end
    b.cmt_valid = '0;
    b.mem_req_ready = 1'b1;
    while (got < 6 && n < 60) begin
      if (b.mem_req_valid === 1'b1) begin
        gtid[got] = int'(b.mem_req_tid); gaddr[got] = b.mem_req_addr; gdata[got] = b.mem_req_data; got++;
      end
      step(); n++;
    end
    b.mem_req_ready = 1'b0;
    n_run++; if (got != 6) begin n_fail++; $display("FAIL rr_count: got %0d grants want 6", got); end
    for (int j = 0; j < got; j++) begin
      ea = ((j % 2) == 0 ? 64'h400 : 64'h500) + 64'(8 * (j / 2));
      ed = ((j % 2) == 0 ? 64'hA0 : 64'hB0) + 64'(j / 2);
      n_run++; if (gtid[j] != (j % 2) || gaddr[j] !== ea || gdata[j] !== ed) begin
        n_fail++; $display("FAIL rr_grant%0d: got t=%0d a=%h d=%h want t=%0d a=%h d=%h", j, gtid[j], gaddr[j], gdata[j], j % 2, ea, ed); end
    end
  endtask

  task automatic test_cmt_err();
    bit ok;
    do_reset();
    disp(0, 5, 64'h77); agu(0, 0, 64'h600);
    commit(0, 6);
    n_run++; if (b.cmt_err !== 1'b1) begin n_fail++; $display("FAIL err_pulse: got %b want 1", b.cmt_err); end
    step();
    n_run++; if (b.cmt_err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", b.cmt_err); end
    commit(0, 5);
    n_run++; if (b.cmt_err !== 1'b0) begin n_fail++; $display("FAIL err_cptr_kept: got %b want 0", b.cmt_err); end
    wait_req(ok);
    n_run++; if (!ok || b.mem_req_addr !== 64'h600 || b.mem_req_data !== 64'h77) begin
      n_fail++; $display("FAIL err_then_drain: got v=%b a=%h d=%h want 1 600 77", b.mem_req_valid, b.mem_req_addr, b.mem_req_data); end
    b.mem_req_ready = 1'b1; step(); b.mem_req_ready = 1'b0;
  endtask

  task automatic test_reset_mid_send();
    bit ok;
    do_reset();
    disp(0, 1, 64'h11); agu(0, 0, 64'h700); commit(0, 1);
    wait_req(ok);
    n_run++; if (!ok) begin n_fail++; $display("FAIL midsend_setup: got v=%b want 1", b.mem_req_valid); end
    #1 rst = 1'b1; #1;
    n_run++; if (b.mem_req_valid !== 1'b0 || b.mem_req_addr !== '0 || b.empty !== 2'b11 || b.full !== 2'b00) begin
      n_fail++; $display("FAIL midsend_reset: got v=%b a=%h empty=%b full=%b want 0 0 11 00", b.mem_req_valid, b.mem_req_addr, b.empty, b.full); end
    step(); rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_drain_hold();
    test_full_wrap();
    test_squash();
    test_back_to_back();
    test_cmt_err();
    test_reset_mid_send();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
